// File: rtl/jtbubl_pkg.sv
// Shared definitions for the Bubble Bobble graphics ROM slots.
// FSM encoding, SDRAM address width and per-slot ROM region bases.
package jtbubl_pkg;

    localparam int SDRAM_AW = 22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } slot_state_e;

    // Half-word bases of each graphics region inside SDRAM
    localparam logic [SDRAM_AW-1:0] SCR_OFFSET = 22'h000000;
    localparam logic [SDRAM_AW-1:0] OBJ_OFFSET = 22'h010000;
    localparam logic [SDRAM_AW-1:0] PAL_OFFSET = 22'h020000;

endpackage

// File: rtl/jtbubl_rom_slot.sv
// Single-entry cached ROM slot bridging a gfx requester to SDRAM.
// Misses issue a held request; the returned word refills the cache.
module jtbubl_rom_slot
    import jtbubl_pkg::*;
#(
    parameter int                AW     = 18,
    parameter int                SDW    = SDRAM_AW,
    parameter logic [SDW-1:0]    OFFSET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              downloading,
    input  logic              rom_cs,
    input  logic [AW-1:0]     rom_addr,
    output logic [31:0]       rom_data,
    output logic              rom_ok,
    output logic              sdram_req,
    output logic [SDW-1:0]    sdram_addr,
    input  logic              sdram_ack,
    input  logic              data_rdy,
    input  logic [31:0]       data_read
);

    slot_state_e    state_q, state_d;
    logic [AW-1:0]  req_addr_q, req_addr_d;
    logic           sdram_req_q, sdram_req_d;
    logic [SDW-1:0] sdram_addr_q, sdram_addr_d;
    logic [31:0]    cache_data_q, cache_data_d;
    logic [AW-1:0]  cache_addr_q, cache_addr_d;
    logic           cache_valid_q, cache_valid_d;
    logic           drop_q, drop_d;
    logic           hit;

    assign hit        = cache_valid_q && (cache_addr_q == rom_addr);
    assign rom_ok     = rom_cs && hit;
    assign rom_data   = cache_data_q;
    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        sdram_req_d   = sdram_req_q;
        sdram_addr_d  = sdram_addr_q;
        cache_data_d  = cache_data_q;
        cache_addr_d  = cache_addr_q;
        cache_valid_d = cache_valid_q;
        drop_d        = drop_q;
        unique case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (rom_cs && !hit && !downloading) begin
                    state_d      = ST_REQ;
                    req_addr_d   = rom_addr;
                    sdram_req_d  = 1'b1;
                    sdram_addr_d = OFFSET + SDW'({rom_addr, 1'b0});
                end
            end
            ST_REQ: begin
                if (downloading) drop_d = 1'b1;
                if (sdram_ack) begin
                    state_d     = ST_WAIT;
                    sdram_req_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (downloading) drop_d = 1'b1;
                if (data_rdy) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                    // A download during the fetch makes the word stale
                    if (!drop_q && !downloading) begin
                        cache_data_d  = data_read;
                        cache_addr_d  = req_addr_q;
                        cache_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                sdram_req_d = 1'b0;
            end
        endcase
        if (downloading) cache_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            req_addr_q    <= '0;
            sdram_req_q   <= 1'b0;
            sdram_addr_q  <= '0;
            cache_data_q  <= '0;
            cache_addr_q  <= '0;
            cache_valid_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            sdram_req_q   <= sdram_req_d;
            sdram_addr_q  <= sdram_addr_d;
            cache_data_q  <= cache_data_d;
            cache_addr_q  <= cache_addr_d;
            cache_valid_q <= cache_valid_d;
            drop_q        <= drop_d;
        end
    end

endmodule

// File: tb/tb_jtbubl_rom_slot.sv
// Bench for jtbubl_rom_slot: directed table, reset/wrap cases,
// and random traffic against a transaction-level model.
module tb_jtbubl_rom_slot;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        downloading;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_rdy;
    logic [31:0] data_read;

    logic        b_cs;
    logic [17:0] b_addr;
    logic [31:0] b_data;
    logic        b_ok;
    logic        b_req;
    logic [21:0] b_saddr;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    jtbubl_rom_slot #(
        .AW(18), .SDW(22), .OFFSET(22'h010000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_data(rom_data), .rom_ok(rom_ok),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .data_rdy(data_rdy),
        .data_read(data_read)
    );

    jtbubl_rom_slot #(
        .AW(18), .SDW(22), .OFFSET(22'h3FFFFE)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_n), .downloading(1'b0),
        .rom_cs(b_cs), .rom_addr(b_addr),
        .rom_data(b_data), .rom_ok(b_ok),
        .sdram_req(b_req), .sdram_addr(b_saddr),
        .sdram_ack(1'b0), .data_rdy(1'b0),
        .data_read(32'h0)
    );

    typedef struct packed {
        logic        cs;
        logic [17:0] addr;
        logic        dl;
        logic        ack;
        logic        rdy;
        logic [31:0] din;
        logic        ok;
        logic [31:0] xdata;
        logic        req;
        logic [21:0] saddr;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic cs, input logic [17:0] addr, input logic dl,
        input logic ack, input logic rdy, input logic [31:0] din,
        input logic ok, input logic [31:0] xdata,
        input logic req, input logic [21:0] saddr);
        vec_t v;
        v = '{cs, addr, dl, ack, rdy, din, ok, xdata, req, saddr};
        return v;
    endfunction

    function automatic logic [21:0] exp_saddr(input logic [21:0] off,
                                              input logic [17:0] a);
        longint s;
        s = (longint'(off) + 2 * longint'(a)) % (longint'(1) << 22);
        return 22'(s);
    endfunction

    function automatic logic [31:0] mem_word(input logic [17:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    task automatic idle_in();
        rom_cs = 0; rom_addr = '0; downloading = 0;
        sdram_ack = 0; data_rdy = 0; data_read = '0;
    endtask

    // transaction-level reference state
    logic        m_valid, m_out, m_acked, m_drop, m_hit;
    logic [17:0] m_addr, m_raddr;
    logic [31:0] m_data;

    initial begin
        rst_n = 0;
        idle_in();
        b_cs = 0; b_addr = '0;

        // reset state
        @(negedge clk);
        rom_cs = 1;
        #1;
        chk("rst_req", 32'(sdram_req), 32'd0);
        chk("rst_ok", 32'(rom_ok), 32'd0);
        chk("rst_saddr", 32'(sdram_addr), 32'd0);
        chk("rst_data", rom_data, 32'd0);
        @(negedge clk);
        idle_in();
        rst_n = 1;

        tbl[0]  = mk(1, 18'h123, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 18'h123, 0, 1, 0, 0, 0, 0, 1, 22'h10246);
        tbl[2]  = mk(1, 18'h123, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 18'h123, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0);
        tbl[4]  = mk(1, 18'h123, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
        tbl[5]  = mk(1, 18'h123, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
        tbl[6]  = mk(1, 18'h010, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 18'h010, 0, 1, 0, 0, 0, 0, 1, 22'h10020);
        tbl[8]  = mk(1, 18'h011, 0, 0, 1, 32'h11111111, 0, 0, 0, 0);
        tbl[9]  = mk(1, 18'h011, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = mk(1, 18'h011, 0, 1, 0, 0, 0, 0, 1, 22'h10022);
        tbl[11] = mk(1, 18'h010, 0, 0, 0, 0, 1, 32'h11111111, 0, 0);
        tbl[12] = mk(1, 18'h011, 0, 0, 1, 32'h22222222, 0, 0, 0, 0);
        tbl[13] = mk(1, 18'h011, 0, 0, 0, 0, 1, 32'h22222222, 0, 0);
        tbl[14] = mk(1, 18'h050, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 18'h050, 0, 1, 0, 0, 0, 0, 1, 22'h100A0);
        tbl[16] = mk(1, 18'h050, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[17] = mk(1, 18'h050, 1, 0, 1, 32'h33333333, 0, 0, 0, 0);
        tbl[18] = mk(1, 18'h050, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(1, 18'h011, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[20] = mk(1, 18'h050, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[21] = mk(1, 18'h050, 0, 1, 0, 0, 0, 0, 1, 22'h100A0);
        tbl[22] = mk(1, 18'h050, 0, 0, 1, 32'h44444444, 0, 0, 0, 0);
        tbl[23] = mk(1, 18'h050, 0, 0, 0, 0, 1, 32'h44444444, 0, 0);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            rom_cs = tbl[i].cs; rom_addr = tbl[i].addr;
            downloading = tbl[i].dl; sdram_ack = tbl[i].ack;
            data_rdy = tbl[i].rdy; data_read = tbl[i].din;
            #1;
            chk($sformatf("tbl%0d_ok", i), 32'(rom_ok), 32'(tbl[i].ok));
            if (tbl[i].ok)
                chk($sformatf("tbl%0d_data", i), rom_data, tbl[i].xdata);
            chk($sformatf("tbl%0d_req", i), 32'(sdram_req),
                32'(tbl[i].req));
            if (tbl[i].req)
                chk($sformatf("tbl%0d_saddr", i), 32'(sdram_addr),
                    32'(tbl[i].saddr));
        end

        // async reset while waiting for data
        @(negedge clk);
        idle_in(); rom_cs = 1; rom_addr = 18'h200;
        @(negedge clk);
        sdram_ack = 1;
        #1 chk("mw_req", 32'(sdram_req), 32'd1);
        @(negedge clk);
        sdram_ack = 0; rom_addr = 18'h050;
        #1 chk("mw_hit", 32'(rom_ok), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("mw_rst_req", 32'(sdram_req), 32'd0);
        chk("mw_rst_ok", 32'(rom_ok), 32'd0);
        @(negedge clk);
        rst_n = 1; rom_addr = 18'h200;
        @(negedge clk);
        #1 chk("mw_relaunch", 32'(sdram_req), 32'd1);
        @(negedge clk);
        idle_in(); rst_n = 0;
        @(negedge clk);
        rst_n = 1;

        // random traffic
        m_valid = 0; m_out = 0; m_acked = 0; m_drop = 0;
        m_addr = '0; m_raddr = '0; m_data = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rom_cs = ($urandom_range(0, 3) != 0);
            rom_addr = 18'h100 + 18'($urandom_range(0, 3));
            downloading = ($urandom_range(0, 15) == 0);
            if (m_out && !m_acked)
                sdram_ack = $urandom_range(0, 1) == 1;
            else
                sdram_ack = $urandom_range(0, 7) == 0;
            if (m_out && m_acked) begin
                data_rdy = $urandom_range(0, 2) == 0;
                data_read = mem_word(m_raddr);
            end else begin
                data_rdy = $urandom_range(0, 7) == 0;
                data_read = $urandom;
            end
            #1;
            m_hit = m_valid && (m_addr == rom_addr);
            chk("rnd_ok", 32'(rom_ok), 32'(rom_cs && m_hit));
            if (rom_cs && m_hit)
                chk("rnd_data", rom_data, m_data);
            chk("rnd_req", 32'(sdram_req), 32'(m_out && !m_acked));
            if (m_out && !m_acked)
                chk("rnd_saddr", 32'(sdram_addr),
                    32'(exp_saddr(22'h010000, m_raddr)));
            @(posedge clk);
            if (m_out) begin
                if (downloading) m_drop = 1;
                if (!m_acked) begin
                    if (sdram_ack) m_acked = 1;
                end else if (data_rdy) begin
                    if (!m_drop) begin
                        m_valid = 1; m_addr = m_raddr;
                        m_data = data_read;
                    end
                    m_out = 0;
                end
            end else if (rom_cs && !m_hit && !downloading) begin
                m_out = 1; m_acked = 0; m_drop = 0;
                m_raddr = rom_addr;
            end
            if (downloading) m_valid = 0;
        end

        // address wrap on the high-offset slot
        @(negedge clk);
        idle_in();
        b_cs = 1; b_addr = 18'h1;
        @(negedge clk);
        #1;
        chk("wrap_req", 32'(b_req), 32'd1);
        chk("wrap_saddr", 32'(b_saddr),
            32'(exp_saddr(22'h3FFFFE, 18'h1)));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
